// File: rtl/i2s_capture.sv
// I2S master receiver: derives mclk/sck/lrck from clk and deserializes the ADC
// stream into 16-bit left/right pairs offered over a valid/ready handshake.
module i2s_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        audio_sdout,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic [15:0] left_data,
  output logic [15:0] right_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clr
);

  logic [8:0]  div_cnt;
  logic [1:0]  sync_q;
  logic        sd_s;
  logic [15:0] shift_q;
  logic [15:0] shift_d;
  logic [15:0] left_hold;
  logic        left_ok;
  logic        sample_evt;
  logic        word_done;
  logic        emit;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sync_q  <= '0;
    end else begin
      div_cnt <= div_cnt + 9'd1;
      sync_q  <= {sync_q[0], audio_sdout};
    end
  end

  // Clocks come straight off counter flops, so they are glitch-free.
  assign audio_mclk = div_cnt[1];
  assign audio_sck  = div_cnt[3];
  assign audio_lrck = div_cnt[8];
  assign sd_s       = sync_q[1];

  always_comb begin
    sample_evt = (div_cnt[3:0] == 4'd11);
    word_done  = sample_evt && (div_cnt[7:4] == 4'd0);
    shift_d    = {shift_q[14:0], sd_s};
    // Slot 0 of a left half completes the right word of the current frame.
    emit       = word_done && !div_cnt[8] && left_ok && enable;
    accept     = sample_valid && sample_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
    end else begin
      if (sample_evt) begin
        shift_q <= shift_d;
      end
      if (word_done) begin
        if (div_cnt[8]) begin
          left_hold <= shift_d;
          left_ok   <= 1'b1;
        end else begin
          left_ok   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (emit) begin
        left_data    <= left_hold;
        right_data   <= shift_d;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
      if (emit && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: cycle-indexed ADC model and pair-level reference,
// compared against the DUT on every falling clk edge plus directed checkpoints.
module tb_i2s_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        audio_sdout = 1'b0;
  logic        sample_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        sample_valid;
  logic        overrun;
  logic [15:0] left_data;
  logic [15:0] right_data;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          n;
  logic [15:0] lw [64];
  logic [15:0] rw [64];
  logic        m_valid;
  logic        m_ovr;
  logic [15:0] m_l;
  logic [15:0] m_r;

  always #5 clk = ~clk;

  i2s_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .audio_sdout  (audio_sdout),
    .audio_mclk   (audio_mclk),
    .audio_sck    (audio_sck),
    .audio_lrck   (audio_lrck),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // n = number of rising edges since reset release, i.e. the divider phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // ADC word schedule: frame f sends lw[f] in the left half and rw[f] in the
  // right half, each delayed by one sck with its LSB in the next half's slot 0.
  function automatic logic adc_bit(input int t);
    int slot = (t / 16) % 16;
    int half = (t / 256) % 2;
    int f    = (t / 512) % 64;
    if (slot == 0) begin
      if (half == 1)    return lw[f][0];
      else if (t >= 512) return rw[(f + 63) % 64][0];
      else              return 1'b0;
    end
    if (half == 1) return rw[f][16 - slot];
    return lw[f][16 - slot];
  endfunction

  always @(negedge clk) begin
    if (n % 16 == 0) audio_sdout = adc_bit(n);
  end

  // Pair-level reference: frame f's pair is offered from n = 512*f + 524
  // when enable is high at its completion; unaccepted pairs get overwritten.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_l     <= '0;
      m_r     <= '0;
    end else begin
      if (n >= 523 && n % 512 == 11 && enable) begin
        m_l     <= lw[(n / 512 - 1) % 64];
        m_r     <= rw[(n / 512 - 1) % 64];
        m_valid <= 1'b1;
        if (m_valid && !sample_ready) m_ovr <= 1'b1;
        else if (overrun_clr)         m_ovr <= 1'b0;
      end else begin
        if (m_valid && sample_ready) m_valid <= 1'b0;
        if (overrun_clr)             m_ovr   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("mclk",  32'(audio_mclk),   32'((n >> 1) & 1));
    check("sck",   32'(audio_sck),    32'((n >> 3) & 1));
    check("lrck",  32'(audio_lrck),   32'((n >> 8) & 1));
    check("valid", 32'(sample_valid), 32'(m_valid));
    check("ovr",   32'(overrun),      32'(m_ovr));
    check("left",  32'(left_data),    32'(m_l));
    check("right", 32'(right_data),   32'(m_r));
  end

  task automatic run_to(input int t);
    while (n < t) @(negedge clk);
  endtask

  initial begin
    int len;
    int cnt;
    lw[0] = 16'hA5C3;
    rw[0] = 16'h1234;
    for (int i = 1; i < 64; i++) begin
      lw[i] = 16'($urandom);
      rw[i] = 16'($urandom);
    end
    enable = 1'b1;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_left",  32'(left_data),    32'd0);
    check("rst_lrck",  32'(audio_lrck),   32'd0);
    rst_n = 1'b1;

    // streaming with a ready consumer
    run_to(523);
    check("pre_first_valid", 32'(sample_valid), 32'd0);
    run_to(524);
    check("first_valid", 32'(sample_valid), 32'd1);
    check("first_left",  32'(left_data),    32'h0000A5C3);
    check("first_right", 32'(right_data),   32'h00001234);
    run_to(525);
    check("first_pulse_end", 32'(sample_valid), 32'd0);
    run_to(1036);
    check("second_valid", 32'(sample_valid), 32'd1);
    check("second_left",  32'(left_data),    32'(lw[1]));

    // stalled consumer -> overrun on the second emit
    run_to(2100);
    sample_ready = 1'b0;
    run_to(2572);
    check("stall_first_ovr", 32'(overrun), 32'd0);
    check("stall_first_left", 32'(left_data), 32'(lw[4]));
    run_to(3084);
    check("overrun_set",    32'(overrun),    32'd1);
    check("overrun_left",   32'(left_data),  32'(lw[5]));
    check("overrun_right",  32'(right_data), 32'(rw[5]));
    run_to(3300);
    sample_ready = 1'b1;
    run_to(3302);
    check("drain_valid",  32'(sample_valid), 32'd0);
    check("ovr_sticky",   32'(overrun),      32'd1);
    run_to(3310);
    overrun_clr = 1'b1;
    run_to(3311);
    overrun_clr = 1'b0;
    run_to(3312);
    check("ovr_cleared", 32'(overrun), 32'd0);

    // acceptance coinciding with the next emit
    run_to(3320);
    sample_ready = 1'b0;
    run_to(4107);
    check("pending_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    run_to(4108);
    check("coincide_valid", 32'(sample_valid), 32'd1);
    check("coincide_ovr",   32'(overrun),      32'd0);
    check("coincide_left",  32'(left_data),    32'(lw[7]));
    check("coincide_right", 32'(right_data),   32'(rw[7]));
    run_to(4109);
    check("coincide_drop", 32'(sample_valid), 32'd0);

    // enable low across two frames
    run_to(4200);
    enable = 1'b0;
    run_to(4620);
    check("dis_valid_a", 32'(sample_valid), 32'd0);
    run_to(5132);
    check("dis_valid_b", 32'(sample_valid), 32'd0);
    check("dis_ovr",     32'(overrun),      32'd0);
    run_to(5300);
    enable = 1'b1;
    run_to(5644);
    check("resume_valid", 32'(sample_valid), 32'd1);
    check("resume_left",  32'(left_data),    32'(lw[10]));

    // random consumer / enable / clear activity
    run_to(5700);
    while (n < 9000) begin
      sample_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      len = int'($urandom_range(1, 600));
      repeat (len) begin
        overrun_clr = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
    end
    sample_ready = 1'b1;
    enable = 1'b1;
    overrun_clr = 1'b0;

    // asynchronous reset in the middle of a left word
    while (n % 512 != 100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(sample_valid), 32'd0);
    check("async_ovr",   32'(overrun),      32'd0);
    check("async_left",  32'(left_data),    32'd0);
    check("async_right", 32'(right_data),   32'd0);
    check("async_clks",  32'({audio_mclk, audio_sck, audio_lrck}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!sample_valid && cnt < 700) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_latency", 32'(cnt),        32'd524);
    check("reset_left",    32'(left_data),  32'h0000A5C3);
    check("reset_right",   32'(right_data), 32'h00001234);
    run_to(1600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
